// File: rtl/imm_load_sequencer_pkg.sv
// Shared types and encodings for the immediate-load sequencer.
// The EMIT_CSRW state only exists when IMM_SEQ_CSRW_EN is defined.
package imm_load_sequencer_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_CSR
  } imm_type_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_LUI,
    ST_EMIT_ADDI
`ifdef IMM_SEQ_CSRW_EN
    , ST_EMIT_CSRW
`endif
  } imm_seq_state_e;

  // Upper part rounded so that adding the sign-extended low 12 bits restores the value.
  function automatic logic [19:0] imm_hi20(input word_t value);
    word_t biased;
    biased = value + 32'h0000_0800;
    return biased[31:12];
  endfunction

endpackage

// File: rtl/imm_inst_encoder.sv
// Combinational instruction encoder: inverse of the immediate decoder for I/U/CSR formats.
module imm_inst_encoder
  import imm_load_sequencer_pkg::*;
(
  input  imm_type_e   imm_type,
  input  word_t       imm,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [2:0]  funct3,
  input  logic [6:0]  opcode,
  output inst_t       inst
);

  always_comb begin
    inst = '0;
    case (imm_type)
      IMM_U:          inst = {imm[31:12], rd, opcode};
      // CSR address occupies the same field as the I-type immediate.
      IMM_I, IMM_CSR: inst = {imm[11:0], rs1, funct3, rd, opcode};
      default:        inst = '0;
    endcase
  end

endmodule

// File: rtl/imm_load_sequencer.sv
// Emits a minimal LUI/ADDI stream that loads a 32-bit constant into rd.
// Define IMM_SEQ_CSRW_EN to add the optional trailing CSRRW x0,csr,rd.
module imm_load_sequencer
  import imm_load_sequencer_pkg::*;
#(
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_req_rd,
  input  word_t       i_req_value,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output inst_t       o_inst,
  output logic        o_done
`ifdef IMM_SEQ_CSRW_EN
  ,
  input  logic        i_csr_wr_en,
  input  logic [11:0] i_csr_addr
`endif
);

  imm_seq_state_e state_q, state_d, tgt, tail;
  inst_t          inst_q, inst_d;
  logic           inst_valid_q, inst_valid_d;
  logic           done_q, done_d;
  logic [4:0]     rd_q, rd_d;
  logic [19:0]    hi20_q, hi20_d;
  logic [11:0]    lo12_q, lo12_d;
`ifdef IMM_SEQ_CSRW_EN
  logic           csr_wr_q, csr_wr_d;
  logic [11:0]    csr_addr_q, csr_addr_d;
  logic           src_csr_wr;
  logic [11:0]    src_csr_addr;
`endif

  logic        accept, fire;
  logic [4:0]  src_rd;
  logic [19:0] src_hi20;
  logic [11:0] src_lo12;
  logic        need_lui, need_addi;

  imm_type_e   enc_type;
  word_t       enc_imm;
  logic [4:0]  enc_rd, enc_rs1;
  logic [2:0]  enc_f3;
  logic [6:0]  enc_opc;
  inst_t       enc_inst;

  // Plan: pick the next instruction from the request being accepted or the latched one.
  always_comb begin
    accept   = i_req_valid && (state_q == ST_IDLE);
    fire     = inst_valid_q && i_inst_ready;
    src_rd   = accept ? i_req_rd : rd_q;
    src_hi20 = accept ? imm_hi20(i_req_value) : hi20_q;
    src_lo12 = accept ? i_req_value[11:0] : lo12_q;

    need_lui  = (src_rd != 5'd0) && (!SKIP_REDUNDANT || (src_hi20 != 20'd0));
    need_addi = (src_rd != 5'd0) &&
                (!SKIP_REDUNDANT || (src_hi20 == 20'd0) || (src_lo12 != 12'd0));

`ifdef IMM_SEQ_CSRW_EN
    src_csr_wr   = accept ? i_csr_wr_en : csr_wr_q;
    src_csr_addr = accept ? i_csr_addr : csr_addr_q;
    tail         = src_csr_wr ? ST_EMIT_CSRW : ST_IDLE;
`else
    tail         = ST_IDLE;
`endif

    case (state_q)
      ST_IDLE:      tgt = need_lui ? ST_EMIT_LUI : (need_addi ? ST_EMIT_ADDI : tail);
      ST_EMIT_LUI:  tgt = need_addi ? ST_EMIT_ADDI : tail;
      ST_EMIT_ADDI: tgt = tail;
      default:      tgt = ST_IDLE;
    endcase

    enc_type = IMM_I;
    enc_imm  = '0;
    enc_rd   = '0;
    enc_rs1  = '0;
    enc_f3   = F3_ADDI;
    enc_opc  = OPC_OP_IMM;
    case (tgt)
      ST_EMIT_LUI: begin
        enc_type = IMM_U;
        enc_imm  = {src_hi20, 12'h000};
        enc_rd   = src_rd;
        enc_opc  = OPC_LUI;
      end
      ST_EMIT_ADDI: begin
        enc_imm  = {{20{src_lo12[11]}}, src_lo12};
        enc_rd   = src_rd;
        // Without a preceding LUI the low part is added to x0.
        enc_rs1  = need_lui ? src_rd : 5'd0;
      end
`ifdef IMM_SEQ_CSRW_EN
      ST_EMIT_CSRW: begin
        enc_type = IMM_CSR;
        enc_imm  = {20'h00000, src_csr_addr};
        enc_rs1  = src_rd;
        enc_f3   = F3_CSRRW;
        enc_opc  = OPC_SYSTEM;
      end
`endif
      default: ;
    endcase
  end

  imm_inst_encoder u_enc (
    .imm_type (enc_type),
    .imm      (enc_imm),
    .rd       (enc_rd),
    .rs1      (enc_rs1),
    .funct3   (enc_f3),
    .opcode   (enc_opc),
    .inst     (enc_inst)
  );

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    done_d       = 1'b0;
    rd_d         = rd_q;
    hi20_d       = hi20_q;
    lo12_d       = lo12_q;
`ifdef IMM_SEQ_CSRW_EN
    csr_wr_d     = csr_wr_q;
    csr_addr_d   = csr_addr_q;
`endif
    if (accept) begin
      rd_d   = src_rd;
      hi20_d = src_hi20;
      lo12_d = src_lo12;
`ifdef IMM_SEQ_CSRW_EN
      csr_wr_d   = src_csr_wr;
      csr_addr_d = src_csr_addr;
`endif
    end
    // Output register only moves on accept or handshake, so a stalled instruction holds.
    if (accept || fire) begin
      state_d      = tgt;
      inst_valid_d = (tgt != ST_IDLE);
      inst_d       = (tgt != ST_IDLE) ? enc_inst : '0;
      done_d       = (tgt == ST_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rd_q   <= rd_d;
    hi20_q <= hi20_d;
    lo12_q <= lo12_d;
`ifdef IMM_SEQ_CSRW_EN
    csr_wr_q   <= csr_wr_d;
    csr_addr_q <= csr_addr_d;
`endif
  end

  assign o_req_ready  = (state_q == ST_IDLE);
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_done       = done_q;

endmodule
